// File: rtl/x_uart_hex_fmt.sv
// Feeds a UART transmitter with a binary word as uppercase ASCII hex, MSB nibble first,
// optionally terminated by CR LF. One character per valid/accept handshake.
module x_uart_hex_fmt #(
  parameter int p_width = 32,
  parameter bit p_crlf  = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [p_width-1:0] i_word,
  input  logic               i_word_valid,
  output logic               o_word_ready,
  output logic [7:0]         o_data,
  output logic               o_valid,
  input  logic               i_accept
);

  localparam int nibbles = p_width / 4;
  localparam int cnt_w   = (nibbles > 1) ? $clog2(nibbles) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HEX,
    CR,
    LF
  } state_t;

  state_t             state;
  logic [p_width-1:0] shift;
  logic [p_width-1:0] shift_next;
  logic [cnt_w-1:0]   count;

  assign shift_next = shift << 4;

  function automatic logic [7:0] ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Outputs are registered and computed one cycle ahead, so nothing reaches
  // o_data/o_valid combinationally from i_accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      shift        <= '0;
      count        <= '0;
      o_valid      <= 1'b0;
      o_data       <= 8'h00;
      o_word_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_word_valid) begin
            shift        <= i_word;
            count        <= cnt_w'(nibbles - 1);
            state        <= HEX;
            o_valid      <= 1'b1;
            o_word_ready <= 1'b0;
            o_data       <= ascii(i_word[p_width-1 -: 4]);
          end
        end
        HEX: begin
          if (i_accept) begin
            if (count != '0) begin
              shift  <= shift_next;
              count  <= count - 1'b1;
              o_data <= ascii(shift_next[p_width-1 -: 4]);
            end else if (p_crlf) begin
              state  <= CR;
              o_data <= 8'h0D;
            end else begin
              state        <= IDLE;
              o_valid      <= 1'b0;
              o_data       <= 8'h00;
              o_word_ready <= 1'b1;
            end
          end
        end
        CR: begin
          if (i_accept) begin
            state  <= LF;
            o_data <= 8'h0A;
          end
        end
        LF: begin
          if (i_accept) begin
            state        <= IDLE;
            o_valid      <= 1'b0;
            o_data       <= 8'h00;
            o_word_ready <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          o_valid      <= 1'b0;
          o_data       <= 8'h00;
          o_word_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_uart_hex_fmt.sv
// Directed bench for x_uart_hex_fmt: a 32-bit CR/LF instance driven from a vector
// table plus an 8-bit instance without line terminator.
module tb_x_uart_hex_fmt;

  logic        clk;
  logic        rst_n;

  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  data;
  logic        valid;
  logic        accept;

  logic [7:0]  word_b;
  logic        word_valid_b;
  logic        word_ready_b;
  logic [7:0]  data_b;
  logic        valid_b;
  logic        accept_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  x_uart_hex_fmt #(.p_width(32), .p_crlf(1'b1)) dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_word       (word),
    .i_word_valid (word_valid),
    .o_word_ready (word_ready),
    .o_data       (data),
    .o_valid      (valid),
    .i_accept     (accept)
  );

  x_uart_hex_fmt #(.p_width(8), .p_crlf(1'b0)) dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_word       (word_b),
    .i_word_valid (word_valid_b),
    .o_word_ready (word_ready_b),
    .o_data       (data_b),
    .o_valid      (valid_b),
    .i_accept     (accept_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          delay;
    int          stall_at;
    int          inject_at;
    logic [79:0] text;
  } vec_t;

  vec_t vecs[5];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Prints one word on dut_a, accepting each character after v.delay cycles,
  // optionally stalling 200 cycles or injecting a stray word request.
  task automatic apply_stimulus(input vec_t v);
    logic [7:0] held_data;
    bit         held_ok;
    int         n;
    check_output("idle_ready", {31'b0, word_ready}, 32'd1);
    check_output("idle_valid", {31'b0, valid}, 32'd0);
    word       = v.word;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    word       = $urandom();
    for (int i = 0; i < 10; i++) begin
      check_output($sformatf("valid[%0d]", i), {31'b0, valid}, 32'd1);
      check_output($sformatf("char[%0d]", i), {24'b0, data}, {24'b0, v.text[79-8*i -: 8]});
      n = (i == v.stall_at) ? 200 : v.delay;
      held_data = data;
      held_ok   = 1'b1;
      for (int c = 0; c < n; c++) begin
        if (i == v.inject_at && c == 0) begin
          word       = 32'h12345678;
          word_valid = 1'b1;
        end
        @(negedge clk);
        word_valid = 1'b0;
        if (data !== held_data || valid !== 1'b1) held_ok = 1'b0;
      end
      if (n > 0) check_output($sformatf("hold[%0d]", i), {31'b0, held_ok}, 32'd1);
      accept = 1'b1;
      @(negedge clk);
      accept = 1'b0;
    end
    check_output("bubble_valid", {31'b0, valid}, 32'd0);
    check_output("bubble_data", {24'b0, data}, 32'h00);
    check_output("bubble_ready", {31'b0, word_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'hDEADBEEF, 5, -1, -1, {"DEADBEEF", 8'h0D, 8'h0A}};
    vecs[1] = '{32'hA5C3F019, 0, -1, -1, {"A5C3F019", 8'h0D, 8'h0A}};
    vecs[2] = '{32'h89ABCDEF, 1,  3, -1, {"89ABCDEF", 8'h0D, 8'h0A}};
    vecs[3] = '{32'h00000000, 2, -1,  2, {"00000000", 8'h0D, 8'h0A}};
    vecs[4] = '{32'h76543210, 0,  9, -1, {"76543210", 8'h0D, 8'h0A}};

    rst_n        = 1'b0;
    word         = '0;
    word_valid   = 1'b0;
    accept       = 1'b0;
    word_b       = '0;
    word_valid_b = 1'b0;
    accept_b     = 1'b0;
    repeat (3) @(negedge clk);

    check_output("rst_valid", {31'b0, valid}, 32'd0);
    check_output("rst_data", {24'b0, data}, 32'h00);
    check_output("rst_ready", {31'b0, word_ready}, 32'd1);
    check_output("rst_b_ready", {31'b0, word_ready_b}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // An accept pulse while idle must not start anything.
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0;
    @(negedge clk);
    check_output("idle_accept_valid", {31'b0, valid}, 32'd0);

    for (int k = 0; k < 5; k++) begin
      $display("[TB] vector %0d word %h", k, vecs[k].word);
      apply_stimulus(vecs[k]);
    end

    // Narrow instance without CR/LF: exactly two characters.
    word_b       = 8'h9A;
    word_valid_b = 1'b1;
    @(negedge clk);
    word_valid_b = 1'b0;
    check_output("b_valid0", {31'b0, valid_b}, 32'd1);
    check_output("b_char0", {24'b0, data_b}, 32'h39);
    check_output("b_ready_busy", {31'b0, word_ready_b}, 32'd0);
    accept_b = 1'b1;
    @(negedge clk);
    accept_b = 1'b0;
    check_output("b_valid1", {31'b0, valid_b}, 32'd1);
    check_output("b_char1", {24'b0, data_b}, 32'h41);
    accept_b = 1'b1;
    @(negedge clk);
    accept_b = 1'b0;
    check_output("b_done_valid", {31'b0, valid_b}, 32'd0);
    check_output("b_done_ready", {31'b0, word_ready_b}, 32'd1);
    check_output("b_done_data", {24'b0, data_b}, 32'h00);

    // Asynchronous reset after the third accept abandons the line.
    word       = 32'hDEADBEEF;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    repeat (3) begin
      accept = 1'b1;
      @(negedge clk);
      accept = 1'b0;
    end
    check_output("pre_rst_char", {24'b0, data}, 32'h44);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_valid", {31'b0, valid}, 32'd0);
    check_output("async_rst_data", {24'b0, data}, 32'h00);
    check_output("async_rst_ready", {31'b0, word_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus('{32'h0000000F, 1, -1, -1, {"0000000F", 8'h0D, 8'h0A}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
